parallel_to_serial_rf: RTL and testbench

PARALLEL_TO_SERIAL_RF -- requirements
Module: parallel_to_serial_rf

---
 rtl/parallel_to_serial_rf_pkg.sv | 15 +
 rtl/parallel_to_serial_rf_elem_counter.sv | 29 ++
 rtl/parallel_to_serial_rf.sv | 96 +++++++++
 tb/tb_parallel_to_serial_rf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_to_serial_rf_pkg.sv
// Shared serializer/deserializer state encodings and index sizing helper.
// Pure definitions: no latency, no flow control.
package p2s_pkg;

    typedef enum logic [0:0] {
        P2S_IDLE  = 1'b0,
        P2S_SHIFT = 1'b1
    } p2s_state_e;

    // Element index width; a one-element word still needs a 1-bit index.
    function automatic int p2s_idx_w(input int n_elems);
        return (n_elems > 1) ? $clog2(n_elems) : 1;
    endfunction

endpackage

// File: rtl/parallel_to_serial_rf_elem_counter.sv
// Element index counter: returns to 0 on clear/load, saturates at MAX_VAL.
// Latency 1 (registered); advances only when en is high.
module p2s_elem_counter #(
    parameter int MAX_VAL = 1,
    parameter int CNT_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || load) begin
            r_count <= '0;
        end else if (en && (r_count != CNT_W'(MAX_VAL))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/parallel_to_serial_rf.sv
// Parallel-to-serial: element 0 first, one cycle after accept; out_ready stalls hold the element.
// A new word is taken in the same cycle the last element leaves, so words stream without bubbles.
module parallel_to_serial_rf
    import p2s_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int N_ELEMS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*N_ELEMS-1:0]   in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_last
);

    localparam int IDX_W = p2s_idx_w(N_ELEMS);

    p2s_state_e                 r_state;
    p2s_state_e                 w_state_nxt;
    logic [WIDTH*N_ELEMS-1:0]   r_word;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_xfer;

    assign w_last   = (r_state == P2S_SHIFT) && (w_idx == IDX_W'(N_ELEMS - 1));
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= P2S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = P2S_IDLE;
        end else begin
            case (r_state)
                P2S_IDLE: begin
                    if (w_accept) w_state_nxt = P2S_SHIFT;
                end
                P2S_SHIFT: begin
                    if (w_xfer && w_last) w_state_nxt = w_accept ? P2S_SHIFT : P2S_IDLE;
                end
                default: w_state_nxt = P2S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !clear && ((r_state == P2S_IDLE) ||
                               ((r_state == P2S_SHIFT) && out_ready && w_last));
        out_valid = (r_state == P2S_SHIFT);
        out_last  = w_last;
        out       = '0;
        if (r_state == P2S_SHIFT) begin
            for (int k = 0; k < N_ELEMS; k++) begin
                if (w_idx == IDX_W'(k)) out = r_word[k*WIDTH +: WIDTH];
            end
        end
    end

    // Held word is zeroed on clear so nothing of a flushed word lingers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
        end else if (clear) begin
            r_word <= '0;
        end else if (w_accept) begin
            r_word <= in;
        end
    end

    p2s_elem_counter #(
        .MAX_VAL (N_ELEMS - 1),
        .CNT_W   (IDX_W)
    ) u_elem_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (w_xfer && !w_last),
        .load  (w_accept),
        .count (w_idx)
    );

endmodule

// File: tb/tb_parallel_to_serial_rf.sv
// Directed bench: 8x4 serializer for ordering/stall/clear/reset, 4x1 instance for single-element words.
module tb_parallel_to_serial_rf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out;
    logic        out_last;

    logic        s_clear = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [3:0]  s_in = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [3:0]  s_out;
    logic        s_out_last;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    parallel_to_serial_rf #(.WIDTH(8), .N_ELEMS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_last(out_last)
    );

    parallel_to_serial_rf #(.WIDTH(4), .N_ELEMS(1)) dut1 (
        .clk(clk), .rst(rst), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in(s_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out), .out_last(s_out_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vec_cnt++;
        if ({in_ready, out_valid, out, out_last} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b out=%h last=%b, want 1 0 00 0",
                     in_ready, out_valid, out, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        in = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, out, out_last} !== {1'b1, exp[k], (k == 3)}) begin
                err_cnt++;
                $display("FAIL stream_elem%0d: got vld=%b out=%h last=%b, want 1 %h %b",
                         k, out_valid, out, out_last, exp[k], (k == 3));
            end
            tick();
        end
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL stream_done: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
        int xfers = 0;
        in = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy[c];
            #1;
            vec_cnt++;
            if ({out_valid, out} !== {1'b1, exp[c]}) begin
                err_cnt++;
                $display("FAIL stall_cyc%0d: got vld=%b out=%h, want 1 %h", c, out_valid, out, exp[c]);
            end
            if (out_valid && out_ready) xfers++;
            tick();
        end
        vec_cnt++;
        if (xfers != 4 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_total: got xfers=%0d vld=%b, want 4 0", xfers, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        in = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in = 32'h88776655;
        for (int c = 0; c < 8; c++) begin
            vec_cnt++;
            if ({out_valid, out, out_last} !== {1'b1, exp[c], (c == 3 || c == 7)}) begin
                err_cnt++;
                $display("FAIL b2b_elem%0d: got vld=%b out=%h last=%b, want 1 %h %b",
                         c, out_valid, out, out_last, exp[c], (c == 3 || c == 7));
            end
            if (c == 3) begin
                vec_cnt++;
                if (in_ready !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL b2b_in_ready_on_last: in_ready=%b, want 1", in_ready);
                end
            end
            tick();
            if (c == 3) in_valid = 1'b0;
        end
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_done: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_clear();
        logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        in = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        #1;
        vec_cnt++;
        if ({out, in_ready} !== {8'h33, 1'b0}) begin
            err_cnt++;
            $display("FAIL clear_cycle: got out=%h in_ready=%b, want 33 0", out, in_ready);
        end
        tick();
        clear = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, in_ready, out} !== {1'b0, 1'b1, 8'h00}) begin
            err_cnt++;
            $display("FAIL clear_after: got vld=%b rdy=%b out=%h, want 0 1 00", out_valid, in_ready, out);
        end
        in = 32'hDDCCBBAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, out} !== {1'b1, exp[k]}) begin
                err_cnt++;
                $display("FAIL clear_next_elem%0d: got vld=%b out=%h, want 1 %h", k, out_valid, out, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int leaked = 0;
        in = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({out_valid, out, out_last, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL async_rst_immediate: got vld=%b out=%h last=%b rdy=%b, want 0 00 0 1",
                     out_valid, out, out_last, in_ready);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0) leaked++;
        end
        vec_cnt++;
        if (leaked != 0) begin
            err_cnt++;
            $display("FAIL async_rst_leak: %0d cycles with out_valid after reset, want 0", leaked);
        end
    endtask

    task automatic test_single_elem();
        s_in = 4'h5; s_in_valid = 1'b1; s_out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (s_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_idle_ready: in_ready=%b, want 1", s_in_ready);
        end
        tick();
        s_in = 4'hA;
        #1;
        vec_cnt++;
        if ({s_out_valid, s_out, s_out_last, s_in_ready} !== {1'b1, 4'h5, 1'b1, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_first: got vld=%b out=%h last=%b rdy=%b, want 1 5 1 1",
                     s_out_valid, s_out, s_out_last, s_in_ready);
        end
        tick();
        s_in_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({s_out_valid, s_out, s_out_last, s_in_ready} !== {1'b1, 4'hA, 1'b1, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_second: got vld=%b out=%h last=%b rdy=%b, want 1 a 1 1",
                     s_out_valid, s_out, s_out_last, s_in_ready);
        end
        tick();
        vec_cnt++;
        if ({s_out_valid, s_out, s_out_last, s_in_ready} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_done: got vld=%b out=%h last=%b rdy=%b, want 0 0 0 1",
                     s_out_valid, s_out, s_out_last, s_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_single_elem();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
